segment_capture: RTL

SEGMENT_CAPTURE -- requirements
Module: segment_capture

---
 rtl/segment_capture.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/segment_capture.sv
// Captures a multiplexed 7-segment display: qualifies stable digit patterns, stores the decoded
// value per digit and emits a change event through a valid/ready handshake.
module segment_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  dig_n,
    input  logic [7:0]  seg_n,
    output logic [19:0] digits,
    output logic [3:0]  dps,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_digit,
    output logic [4:0]  evt_code,
    output logic        evt_dp,
    output logic        evt_err,
    output logic        ovf,
    input  logic        ovf_clr
);

    localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);
    localparam logic [7:0] StableLast = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StTrack, StLocked} state_e;

    state_e      state_q, state_d;
    logic [7:0]  run_q, run_d;
    logic [3:0]  dig_q, dig_prev_q;
    logic [7:0]  seg_q, seg_prev_q;
    logic [4:0]  code_q [4];
    logic [3:0]  dps_q;
    logic        evt_valid_q, evt_dp_q, evt_err_q, ovf_q;
    logic [1:0]  evt_digit_q;
    logic [4:0]  evt_code_q;

    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic [7:0]  pat;
    logic [4:0]  dec_code;
    logic        dec_err, dec_dp;
    logic        same, qualify, changed, new_evt;

    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (dig_q)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase
    end

    // Decimal point is decoded separately, so mask it out of the pattern.
    always_comb begin
        pat      = ~seg_q & 8'hFE;
        dec_dp   = ~seg_q[0];
        dec_err  = 1'b0;
        dec_code = 5'h1E;
        case (pat)
            8'h7E: dec_code = 5'h00;
            8'h0C: dec_code = 5'h01;
            8'hB6: dec_code = 5'h02;
            8'h9E: dec_code = 5'h03;
            8'hCC: dec_code = 5'h04;
            8'hDA: dec_code = 5'h05;
            8'hFA: dec_code = 5'h06;
            8'h0E: dec_code = 5'h07;
            8'hFE: dec_code = 5'h08;
            8'hCE: dec_code = 5'h09;
            8'hEE: dec_code = 5'h0A;
            8'hF8: dec_code = 5'h0B;
            8'h72: dec_code = 5'h0C;
            8'hBC: dec_code = 5'h0D;
            8'hF2: dec_code = 5'h0E;
            8'hE2: dec_code = 5'h0F;
            8'h70: dec_code = 5'h10;
            8'hA8: dec_code = 5'h11;
            8'hE6: dec_code = 5'h12;
            8'h00: dec_code = 5'h1F;
            default: dec_err = 1'b1;
        endcase
    end

    assign same = (dig_q == dig_prev_q) && (seg_q == seg_prev_q);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        qualify = 1'b0;
        case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    state_d = StTrack;
                    run_d   = 8'd1;
                end
            end
            StTrack: begin
                if (!sel_valid) begin
                    state_d = StIdle;
                    run_d   = 8'd0;
                end else if (!same) begin
                    run_d = 8'd1;
                end else if (run_q == StableLast) begin
                    qualify = 1'b1;
                    state_d = StLocked;
                    run_d   = StableMax;
                end else if (run_q < StableMax) begin
                    run_d = run_q + 8'd1;
                end
            end
            StLocked: begin
                if (!sel_valid) begin
                    state_d = StIdle;
                    run_d   = 8'd0;
                end else if (!same) begin
                    state_d = StTrack;
                    run_d   = 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                run_d   = 8'd0;
            end
        endcase
    end

    assign changed = (dec_code != code_q[sel_idx]) || (dec_dp != dps_q[sel_idx]);
    assign new_evt = qualify && changed;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            run_q       <= 8'd0;
            dig_q       <= 4'hF;
            seg_q       <= 8'hFF;
            dig_prev_q  <= 4'hF;
            seg_prev_q  <= 8'hFF;
            for (int i = 0; i < 4; i++) code_q[i] <= 5'h1F;
            dps_q       <= 4'h0;
            evt_valid_q <= 1'b0;
            evt_digit_q <= 2'd0;
            evt_code_q  <= 5'd0;
            evt_dp_q    <= 1'b0;
            evt_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            dig_q      <= dig_n;
            seg_q      <= seg_n;
            dig_prev_q <= dig_q;
            seg_prev_q <= seg_q;
            if (qualify) begin
                code_q[sel_idx] <= dec_code;
                dps_q[sel_idx]  <= dec_dp;
            end
            if (new_evt && (!evt_valid_q || evt_ready)) begin
                evt_valid_q <= 1'b1;
                evt_digit_q <= sel_idx;
                evt_code_q  <= dec_code;
                evt_dp_q    <= dec_dp;
                evt_err_q   <= dec_err;
            end else if (evt_valid_q && evt_ready) begin
                evt_valid_q <= 1'b0;
            end
            // A drop in the same cycle as ovf_clr keeps the flag set.
            if (new_evt && evt_valid_q && !evt_ready) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign digits    = {code_q[3], code_q[2], code_q[1], code_q[0]};
    assign dps       = dps_q;
    assign evt_valid = evt_valid_q;
    assign evt_digit = evt_digit_q;
    assign evt_code  = evt_code_q;
    assign evt_dp    = evt_dp_q;
    assign evt_err   = evt_err_q;
    assign ovf       = ovf_q;

endmodule
